// File: rtl/rossler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rossler_pkg                                            |
// | Description : Shared state encoding and stream tag values for the    |
// |               rossler sample controller.                             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package rossler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WARMUP = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] TAG_X = 2'd0;
    localparam logic [1:0] TAG_Y = 2'd1;
    localparam logic [1:0] TAG_Z = 2'd2;

    // Q-format of the x/y/z words; data is forwarded untouched.
    localparam int FRAC_BITS = 21;

endpackage
`default_nettype wire

// File: rtl/rossler_triplet_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rossler_triplet_tx                                     |
// | Description : Holds one {x,y,z} triple and serialises it as three    |
// |               tagged words on a valid/ready stream.                  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module rossler_triplet_tx
    import rossler_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] z_i,
    output logic             full_o,
    output logic             last_accept_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic [1:0]       m_tag_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic [1:0]       r_tag;
    logic             r_full;
    logic             w_accept;

    assign w_accept      = r_full && m_ready_i;
    assign last_accept_o = w_accept && (r_tag == TAG_Z);
    assign full_o        = r_full;
    assign m_valid_o     = r_full;
    assign m_tag_o       = r_tag;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_tag  <= TAG_X;
            r_full <= 1'b0;
        end else if (flush_i) begin
            r_tag  <= TAG_X;
            r_full <= 1'b0;
        end else if (load_i) begin
            // Caller only loads when empty or when z leaves this very cycle.
            r_x    <= x_i;
            r_y    <= y_i;
            r_z    <= z_i;
            r_tag  <= TAG_X;
            r_full <= 1'b1;
        end else if (w_accept) begin
            if (r_tag == TAG_Z) begin
                r_tag  <= TAG_X;
                r_full <= 1'b0;
            end else begin
                r_tag <= r_tag + 2'd1;
            end
        end
    end

    always_comb begin
        case (r_tag)
            TAG_Y:   m_data_o = r_y;
            TAG_Z:   m_data_o = r_z;
            default: m_data_o = r_x;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rossler_sample_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rossler_sample_ctrl                                    |
// | Description : Run controller for the rossler core: clear, settle,    |
// |               decimate and stream a programmed number of samples.    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module rossler_sample_ctrl
    import rossler_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ITER_CYCLES  = 2,
    parameter int SETTLE_ITERS = 1024,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 run_i,
    input  logic [CNT_WIDTH-1:0] n_samples_i,
    input  logic [7:0]           decim_i,
    output logic                 osc_rst_o,
    output logic                 osc_start_o,
    input  logic [WIDTH-1:0]     xn_i,
    input  logic [WIDTH-1:0]     yn_i,
    input  logic [WIDTH-1:0]     zn_i,
    output logic [WIDTH-1:0]     m_data_o,
    output logic [1:0]           m_tag_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overrun_o
);

    localparam int PH_W = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
    localparam int ST_W = $clog2(SETTLE_ITERS + 1);
    localparam logic [PH_W-1:0] c_last_phase  = PH_W'(ITER_CYCLES - 1);
    localparam logic [ST_W-1:0] c_last_settle = ST_W'(SETTLE_ITERS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_run_d;
    logic [PH_W-1:0]      r_phase;
    logic [ST_W-1:0]      r_settle;
    logic [7:0]           r_decim;
    logic [7:0]           r_dec_cnt;
    logic [CNT_WIDTH-1:0] r_n;
    logic [CNT_WIDTH-1:0] r_kept;
    logic                 r_overrun;

    logic w_osc_en, w_tick, w_abort, w_dec_hit, w_cap, w_load, w_drop, w_last, w_flush;
    logic w_tx_full, w_tx_last, w_tx_block;

    assign w_osc_en   = (r_state == ST_WARMUP) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_tick     = w_osc_en && (r_phase == c_last_phase);
    assign w_abort    = !run_i && (r_state != ST_IDLE) && (r_state != ST_DONE);
    // Register is free if empty or its z word leaves this cycle.
    assign w_tx_block = w_tx_full && !w_tx_last;
    assign w_dec_hit  = (r_state == ST_RUN) && w_tick && (r_dec_cnt == r_decim - 8'd1);
    assign w_cap      = w_dec_hit && run_i;
    assign w_load     = w_cap && !w_tx_block;
    assign w_drop     = w_cap && w_tx_block;
    assign w_last     = w_load && (r_n != '0) && ((r_kept + CNT_WIDTH'(1)) == r_n);
    assign w_flush    = (w_state_nxt == ST_DONE);

    assign osc_start_o = w_osc_en;
    assign overrun_o   = r_overrun;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        osc_rst_o   = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                osc_rst_o = 1'b1;
                busy_o    = 1'b0;
                if (run_i && !r_run_d) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                osc_rst_o   = 1'b1;
                w_state_nxt = ST_WARMUP;
            end
            ST_WARMUP: if (w_tick && (r_settle == c_last_settle)) w_state_nxt = ST_RUN;
            ST_RUN:    if (w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_tx_last || !w_tx_full) w_state_nxt = ST_DONE;
            ST_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) w_state_nxt = ST_DONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_run_d   <= 1'b0;
            r_phase   <= '0;
            r_settle  <= '0;
            r_decim   <= '0;
            r_dec_cnt <= '0;
            r_n       <= '0;
            r_kept    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_run_d <= run_i;
            r_phase <= (w_osc_en && !w_tick) ? r_phase + PH_W'(1) : '0;

            if (r_state == ST_WARMUP) begin
                if (w_tick) r_settle <= r_settle + ST_W'(1);
            end else begin
                r_settle <= '0;
            end

            if (r_state == ST_RUN) begin
                if (w_tick) r_dec_cnt <= w_dec_hit ? 8'd0 : r_dec_cnt + 8'd1;
            end else begin
                r_dec_cnt <= '0;
            end

            if (r_state == ST_CLEAR) begin
                r_n       <= n_samples_i;
                r_decim   <= (decim_i == 8'd0) ? 8'd1 : decim_i;
                r_kept    <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_load) r_kept <= r_kept + CNT_WIDTH'(1);
                if (w_drop) r_overrun <= 1'b1;
            end
        end
    end

    rossler_triplet_tx #(
        .WIDTH (WIDTH)
    ) u_tx (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (w_flush),
        .load_i        (w_load),
        .x_i           (xn_i),
        .y_i           (yn_i),
        .z_i           (zn_i),
        .full_o        (w_tx_full),
        .last_accept_o (w_tx_last),
        .m_data_o      (m_data_o),
        .m_tag_o       (m_tag_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i)
    );

endmodule
`default_nettype wire

// File: tb/tb_rossler_sample_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_rossler_sample_ctrl                                 |
// | Description : Self-checking bench with a behavioural core/stream     |
// |               model for rossler_sample_ctrl.                         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_rossler_sample_ctrl;

    localparam int IC     = 3;
    localparam int SETTLE = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        run_i = 1'b0;
    logic [15:0] n_samples_i = '0;
    logic [7:0]  decim_i = '0;
    logic        osc_rst_o, osc_start_o;
    logic [31:0] xn_i, yn_i, zn_i;
    logic [31:0] m_data_o;
    logic [1:0]  m_tag_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;
    logic        busy_o, done_o, overrun_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] run_seed = 32'h1234_5678;
    int          core_k = 0;
    int          core_ph = 0;

    rossler_sample_ctrl #(
        .WIDTH        (32),
        .ITER_CYCLES  (IC),
        .SETTLE_ITERS (SETTLE),
        .CNT_WIDTH    (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .run_i       (run_i),
        .n_samples_i (n_samples_i),
        .decim_i     (decim_i),
        .osc_rst_o   (osc_rst_o),
        .osc_start_o (osc_start_o),
        .xn_i        (xn_i),
        .yn_i        (yn_i),
        .zn_i        (zn_i),
        .m_data_o    (m_data_o),
        .m_tag_o     (m_tag_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] fval(input logic [31:0] seed, input int k, input int w);
        return seed ^ ((32'(k) * 32'h9E37_79B1) + (32'(w) * 32'h0123_4567));
    endfunction

    // Stand-in oscillator core: one iterate per IC clocks while enabled.
    always @(posedge clk_i) begin
        if (osc_rst_o) begin
            core_k  <= 0;
            core_ph <= 0;
        end else if (osc_start_o) begin
            if (core_ph == IC - 1) begin
                core_ph <= 0;
                core_k  <= core_k + 1;
            end else begin
                core_ph <= core_ph + 1;
            end
        end
    end

    assign xn_i = fval(run_seed, core_k, 0);
    assign yn_i = fval(run_seed, core_k, 1);
    assign zn_i = fval(run_seed, core_k, 2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int n;
        int dec;
        int rmode;      // 0 always ready, 1 toggling, 2 random, 3 never ready
        int abort_m;    // cycle after WARMUP entry where run_i drops, -1 none
        int exp_words;
        int exp_ovr;    // -1: only the model decides
    } vec_t;

    task automatic run_case(input vec_t v);
        logic [31:0] q[$];
        int  hold;
        int  kept;
        int  ovr;
        int  words;
        int  deff;
        int  t;
        bit  ended;
        hold  = 0;
        kept  = 0;
        ovr   = 0;
        words = 0;
        ended = 0;
        deff  = (v.dec == 0) ? 1 : v.dec;
        run_seed    = $urandom;
        n_samples_i = 16'(v.n);
        decim_i     = 8'(v.dec);
        m_ready_i   = 1'b0;
        run_i       = 1'b1;
        @(negedge clk_i);
        #1;
        chk("clear_osc_rst", osc_rst_o, 1);
        chk("clear_busy", busy_o, 1);
        @(negedge clk_i);
        for (int m = 0; m < 4000; m++) begin
            case (v.rmode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = (m % 2 == 0);
                2:       m_ready_i = ($urandom_range(0, 3) != 0);
                default: m_ready_i = 1'b0;
            endcase
            if (m == v.abort_m) run_i = 1'b0;
            #1;
            chk("valid", m_valid_o, (hold > 0));
            if (hold > 0) begin
                chk("data", m_data_o, q[0]);
                chk("tag", m_tag_o, 3 - hold);
            end
            chk("overrun", overrun_o, ovr);
            chk("osc_start", osc_start_o, 1);
            chk("done_low", done_o, 0);
            if (m_valid_o && m_ready_i) words++;
            if (!run_i) begin
                ended = 1;
            end else begin
                if (hold > 0 && m_ready_i) begin
                    void'(q.pop_front());
                    hold--;
                end
                t = m / IC;
                if ((m % IC == IC - 1) && (t >= SETTLE) && ((t - SETTLE + 1) % deff == 0)
                    && (v.n == 0 || kept < v.n)) begin
                    if (hold == 0) begin
                        q.push_back(fval(run_seed, t, 0));
                        q.push_back(fval(run_seed, t, 1));
                        q.push_back(fval(run_seed, t, 2));
                        hold = 3;
                        kept++;
                    end else begin
                        ovr = 1;
                    end
                end
                if (v.n != 0 && kept == v.n && hold == 0) ended = 1;
            end
            @(negedge clk_i);
            if (ended) break;
        end
        if (!ended) chk("run_timeout", 0, 1);
        m_ready_i = 1'b0;
        #1;
        chk("done_pulse", done_o, 1);
        chk("done_valid", m_valid_o, 0);
        chk("done_osc_start", osc_start_o, 0);
        run_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("idle_done", done_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_osc_rst", osc_rst_o, 1);
        chk("ovr_model", overrun_o, ovr);
        if (v.exp_ovr >= 0) chk("ovr_table", overrun_o, v.exp_ovr);
        chk("words", words, v.exp_words);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{3, 1, 0, -1,  9, 0};
        tbl[1] = '{2, 5, 0, -1,  6, 0};
        tbl[2] = '{4, 2, 1, -1, 12, 0};
        tbl[3] = '{0, 1, 3, 40,  0, 1};
        tbl[4] = '{1, 1, 3, 25,  0, 0};
        tbl[5] = '{3, 1, 0,  5,  0, 0};
        tbl[6] = '{2, 0, 0, -1,  6, 0};
        tbl[7] = '{2, 1, 1, -1,  6, 1};

        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_osc_rst", osc_rst_o, 1);
        chk("rst_osc_start", osc_start_o, 0);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_tag", m_tag_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_overrun", overrun_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 8; i++) run_case(tbl[i]);

        // Reset in the middle of a run while a word is pending.
        n_samples_i = 16'd0;
        decim_i     = 8'd1;
        m_ready_i   = 1'b0;
        run_i       = 1'b1;
        for (int c = 0; c < 100 && !m_valid_o; c++) @(negedge clk_i);
        chk("pre_reset_valid", m_valid_o, 1);
        rst_i = 1'b1;
        run_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("midrst_valid", m_valid_o, 0);
        chk("midrst_osc_rst", osc_rst_o, 1);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_overrun", overrun_o, 0);
        chk("midrst_data", m_data_o, 0);
        @(negedge clk_i);
        #1;
        chk("midrst_stays_idle", busy_o, 0);
        @(negedge clk_i);

        for (int i = 0; i < 6; i++) begin
            vec_t r;
            r.n         = $urandom_range(1, 4);
            r.dec       = $urandom_range(0, 4);
            r.rmode     = 2;
            r.abort_m   = -1;
            r.exp_words = 3 * r.n;
            r.exp_ovr   = -1;
            run_case(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
